iob_eth_rx_buf_ctrl: RTL and testbench

Ring-buffer controller that sequences the Ethernet receive engine across NBUF frame buffers in packet memory. It hands the receiver a free buffer index and answers the receiver's level-held frame-received indication with a one-cycle acknowledge. It queues completed frames (length, CRC status) for the CPU and recycles each buffer when the CPU releases it. It sits between the receive engine (already synchronised into the system clock domain) and the CPU register file.

---
 rtl/iob_eth_rx_buf_ctrl_pkg.sv | 16 +
 rtl/iob_eth_rx_buf_ctrl_sat_cnt.sv | 24 ++
 rtl/iob_eth_rx_buf_ctrl.sv | 170 +++++++++++++++++
 tb/tb_iob_eth_rx_buf_ctrl.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/iob_eth_rx_buf_ctrl_pkg.sv
// Shared definitions for the Ethernet receive ring-buffer controller:
// receive FSM state encodings and the default descriptor field widths.
package iob_eth_rx_buf_ctrl_pkg;

    typedef enum logic [1:0] {
        RX_IDLE    = 2'd0,
        RX_FILL    = 2'd1,
        RX_RELEASE = 2'd2
    } rx_state_t;

    localparam int RX_NBUF_DEF  = 4;
    localparam int RX_IDX_W_DEF = 2;
    localparam int RX_LEN_W_DEF = 11;
    localparam int RX_CNT_W_DEF = 16;

endpackage

// File: rtl/iob_eth_rx_buf_ctrl_sat_cnt.sv
// Saturating event counter with synchronous clear.
// Clear wins over an increment in the same cycle; the count sticks at all-ones.
module iob_eth_sat_cnt #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    // count up on inc, hold at all-ones, clear on clr
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != '1)) begin
            cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/iob_eth_rx_buf_ctrl.sv
// Receive ring-buffer controller: hands the receive engine a free buffer,
// acknowledges each completed frame with a one-cycle rx_ack, queues frame
// descriptors (length, CRC status) for the CPU and recycles buffers on
// cpu_release.
//
// Handshake: rx_frame_done is a level held by the receiver until it sees
// rx_ack; rx_ack is a single-cycle pulse, and the FSM waits in RX_RELEASE for
// rx_frame_done to drop so one frame is never counted twice. cpu_release is a
// one-cycle pulse that frees the oldest queued frame (ignored when empty).
//
// Optional build macro: IOB_ETH_RX_CRC_DROP_EN -- frames failing CRC are
// acknowledged but discarded and counted in crc_err_cnt. Without it, bad
// frames are queued with cpu_crc_err=1 and crc_err_cnt reads 0.
module iob_eth_rx_buf_ctrl
    import iob_eth_rx_buf_ctrl_pkg::*;
#(
    parameter int NBUF  = RX_NBUF_DEF,
    parameter int IDX_W = RX_IDX_W_DEF,
    parameter int LEN_W = RX_LEN_W_DEF,
    parameter int CNT_W = RX_CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    output logic             rx_buf_avail,
    output logic [IDX_W-1:0] rx_buf_idx,
    input  logic             rx_frame_done,
    input  logic [LEN_W-1:0] rx_frame_len,
    input  logic             rx_crc_ok,
    output logic             rx_ack,
    output logic             cpu_frame_valid,
    output logic [IDX_W-1:0] cpu_buf_idx,
    output logic [LEN_W-1:0] cpu_frame_len,
    output logic             cpu_crc_err,
    input  logic             cpu_release,
    input  logic             irq_en,
    output logic             irq,
    input  logic             cnt_clr,
    output logic [CNT_W-1:0] drop_cnt,
    output logic [CNT_W-1:0] crc_err_cnt,
    output logic [1:0]       state_dbg
);

    localparam logic [IDX_W:0] FULL = (IDX_W+1)'(NBUF);

    rx_state_t        state;
    logic [IDX_W-1:0] wr_ptr;
    logic [IDX_W-1:0] rd_ptr;
    logic [IDX_W:0]   count;
    logic [LEN_W-1:0] desc_len [NBUF];

    logic fill_done;
    logic commit;
    logic release_ok;
    logic drop_inc;
`ifdef IOB_ETH_RX_CRC_DROP_EN
    logic crc_inc;
`else
    logic desc_err [NBUF];
`endif

    // decode commit / drop / release events from current state and inputs
    always_comb begin
        fill_done  = (state == RX_FILL) && rx_frame_done;
`ifdef IOB_ETH_RX_CRC_DROP_EN
        commit     = fill_done && rx_crc_ok;
        crc_inc    = fill_done && !rx_crc_ok;
`else
        commit     = fill_done;
`endif
        drop_inc   = (state == RX_IDLE) && (count == FULL) && rx_frame_done;
        release_ok = cpu_release && (count != '0);
    end

    // receive FSM with registered one-cycle acknowledge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= RX_IDLE;
            rx_ack <= 1'b0;
        end else begin
            rx_ack <= 1'b0;
            case (state)
                RX_IDLE: begin
                    if (count != FULL) begin
                        state <= RX_FILL;
                    end else if (rx_frame_done) begin
                        rx_ack <= 1'b1;
                        state  <= RX_RELEASE;
                    end
                end
                RX_FILL: begin
                    if (rx_frame_done) begin
                        rx_ack <= 1'b1;
                        state  <= RX_RELEASE;
                    end
                end
                RX_RELEASE: begin
                    if (!rx_frame_done) begin
                        state <= RX_IDLE;
                    end
                end
                default: state <= RX_IDLE;
            endcase
        end
    end

    // ring pointers and occupancy; simultaneous commit and release keep count
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (commit)     wr_ptr <= wr_ptr + IDX_W'(1);
            if (release_ok) rd_ptr <= rd_ptr + IDX_W'(1);
            case ({commit, release_ok})
                2'b10:   count <= count + (IDX_W+1)'(1);
                2'b01:   count <= count - (IDX_W+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // descriptor store written at wr_ptr on commit
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NBUF; i++) begin
                desc_len[i] <= '0;
`ifndef IOB_ETH_RX_CRC_DROP_EN
                desc_err[i] <= 1'b0;
`endif
            end
        end else if (commit) begin
            desc_len[wr_ptr] <= rx_frame_len;
`ifndef IOB_ETH_RX_CRC_DROP_EN
            desc_err[wr_ptr] <= !rx_crc_ok;
`endif
        end
    end

    iob_eth_sat_cnt #(.W(CNT_W)) u_drop_cnt (
        .clk (clk),
        .rst (rst),
        .clr (cnt_clr),
        .inc (drop_inc),
        .cnt (drop_cnt)
    );

`ifdef IOB_ETH_RX_CRC_DROP_EN
    iob_eth_sat_cnt #(.W(CNT_W)) u_crc_err_cnt (
        .clk (clk),
        .rst (rst),
        .clr (cnt_clr),
        .inc (crc_inc),
        .cnt (crc_err_cnt)
    );
    assign cpu_crc_err = 1'b0;
`else
    assign crc_err_cnt = '0;
    assign cpu_crc_err = desc_err[rd_ptr];
`endif

    assign rx_buf_avail    = (state == RX_FILL);
    assign rx_buf_idx      = wr_ptr;
    assign cpu_buf_idx     = rd_ptr;
    assign cpu_frame_len   = desc_len[rd_ptr];
    assign cpu_frame_valid = (count != '0);
    assign irq             = irq_en & cpu_frame_valid;
    assign state_dbg       = state;

endmodule

// File: tb/tb_iob_eth_rx_buf_ctrl.sv
// Directed testbench for iob_eth_rx_buf_ctrl (NBUF=4). Works with or without
// IOB_ETH_RX_CRC_DROP_EN defined.
module tb_iob_eth_rx_buf_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        rx_buf_avail;
    logic [1:0]  rx_buf_idx;
    logic        rx_frame_done;
    logic [10:0] rx_frame_len;
    logic        rx_crc_ok;
    logic        rx_ack;
    logic        cpu_frame_valid;
    logic [1:0]  cpu_buf_idx;
    logic [10:0] cpu_frame_len;
    logic        cpu_crc_err;
    logic        cpu_release;
    logic        irq_en;
    logic        irq;
    logic        cnt_clr;
    logic [15:0] drop_cnt;
    logic [15:0] crc_err_cnt;
    logic [1:0]  state_dbg;

    int n_tests = 0;
    int n_fail  = 0;
    int acks;
    int first;

    // clock and reset
    always #5 clk = ~clk;

    iob_eth_rx_buf_ctrl dut (
        .clk             (clk),
        .rst             (rst),
        .rx_buf_avail    (rx_buf_avail),
        .rx_buf_idx      (rx_buf_idx),
        .rx_frame_done   (rx_frame_done),
        .rx_frame_len    (rx_frame_len),
        .rx_crc_ok       (rx_crc_ok),
        .rx_ack          (rx_ack),
        .cpu_frame_valid (cpu_frame_valid),
        .cpu_buf_idx     (cpu_buf_idx),
        .cpu_frame_len   (cpu_frame_len),
        .cpu_crc_err     (cpu_crc_err),
        .cpu_release     (cpu_release),
        .irq_en          (irq_en),
        .irq             (irq),
        .cnt_clr         (cnt_clr),
        .drop_cnt        (drop_cnt),
        .crc_err_cnt     (crc_err_cnt),
        .state_dbg       (state_dbg)
    );

    // scoreboard check
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst           = 1'b1;
        rx_frame_done = 1'b0;
        rx_frame_len  = '0;
        rx_crc_ok     = 1'b1;
        cpu_release   = 1'b0;
        cnt_clr       = 1'b0;
        irq_en        = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        tick();
    endtask

    // hold rx_frame_done for 'hold' cycles, then drop it for two cycles,
    // counting rx_ack pulses and the cycle of the first one
    task automatic send_frame(input logic [10:0] len, input logic ok, input int hold,
                              output int n_ack, output int first_ack);
        n_ack         = 0;
        first_ack     = -1;
        rx_frame_done = 1'b1;
        rx_frame_len  = len;
        rx_crc_ok     = ok;
        for (int i = 1; i <= hold + 2; i++) begin
            if (i == hold + 1) rx_frame_done = 1'b0;
            tick();
            if (rx_ack) begin
                n_ack++;
                if (first_ack < 0) first_ack = i;
            end
        end
    endtask

    task automatic rel_pulse();
        cpu_release = 1'b1;
        tick();
        cpu_release = 1'b0;
    endtask

    // watchdog
    initial begin
        #200000;
        n_fail++;
        $display("FAIL watchdog: got timeout expected finish");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // driver
    initial begin
        rst           = 1'b1;
        rx_frame_done = 1'b0;
        rx_frame_len  = '0;
        rx_crc_ok     = 1'b1;
        cpu_release   = 1'b0;
        cnt_clr       = 1'b0;
        irq_en        = 1'b1;

        // 1: reset values, then idle
        tick();
        tick();
        chk("rst_avail", rx_buf_avail, 0);
        chk("rst_idx", rx_buf_idx, 0);
        chk("rst_valid", cpu_frame_valid, 0);
        chk("rst_irq", irq, 0);
        chk("rst_ack", rx_ack, 0);
        chk("rst_drop", drop_cnt, 0);
        chk("rst_crc", crc_err_cnt, 0);
        chk("rst_state", state_dbg, 0);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        chk("idle_avail", rx_buf_avail, 1);
        chk("idle_idx", rx_buf_idx, 0);
        chk("idle_valid", cpu_frame_valid, 0);
        chk("idle_irq", irq, 0);
        chk("idle_state", state_dbg, 1);

        // 2: single good frame, done held 4 cycles
        send_frame(11'd64, 1'b1, 4, acks, first);
        chk("f1_acks", acks, 1);
        chk("f1_ack_lat", first, 1);
        chk("f1_valid", cpu_frame_valid, 1);
        chk("f1_cidx", cpu_buf_idx, 0);
        chk("f1_len", cpu_frame_len, 64);
        chk("f1_crcerr", cpu_crc_err, 0);
        chk("f1_irq", irq, 1);
        chk("f1_ridx", rx_buf_idx, 1);
        chk("f1_avail", rx_buf_avail, 1);
        irq_en = 1'b0;
        #1;
        chk("f1_irq_off", irq, 0);
        irq_en = 1'b1;

        // 3: fill the ring, drop the 5th, release frees a slot
        do_reset();
        for (int i = 0; i < 4; i++) begin
            send_frame(11'(100 + i), 1'b1, 3, acks, first);
            chk("fill_acks", acks, 1);
            chk("fill_lat", first, 1);
        end
        chk("full_avail", rx_buf_avail, 0);
        chk("full_valid", cpu_frame_valid, 1);
        chk("full_cidx", cpu_buf_idx, 0);
        chk("full_len", cpu_frame_len, 100);
        chk("full_ridx", rx_buf_idx, 0);
        send_frame(11'd200, 1'b1, 3, acks, first);
        chk("drop_acks", acks, 1);
        chk("drop_lat", first, 1);
        chk("drop_cnt1", drop_cnt, 1);
        chk("drop_avail", rx_buf_avail, 0);
        chk("drop_len", cpu_frame_len, 100);
        rel_pulse();
        chk("rel_cidx", cpu_buf_idx, 1);
        chk("rel_len", cpu_frame_len, 101);
        chk("rel_avail0", rx_buf_avail, 0);
        tick();
        chk("rel_avail1", rx_buf_avail, 1);
        chk("rel_ridx", rx_buf_idx, 0);

        // 4: commit and release together, pointer wrap, release when empty
        do_reset();
        for (int i = 0; i < 3; i++) send_frame(11'(10 + i), 1'b1, 2, acks, first);
        rx_frame_done = 1'b1;
        rx_frame_len  = 11'd13;
        rx_crc_ok     = 1'b1;
        cpu_release   = 1'b1;
        tick();
        cpu_release = 1'b0;
        chk("both_ack", rx_ack, 1);
        chk("both_cidx", cpu_buf_idx, 1);
        chk("both_len", cpu_frame_len, 11);
        chk("both_ridx", rx_buf_idx, 0);
        tick();
        rx_frame_done = 1'b0;
        tick();
        tick();
        chk("both_avail", rx_buf_avail, 1);
        rel_pulse();
        chk("q_cidx2", cpu_buf_idx, 2);
        chk("q_len2", cpu_frame_len, 12);
        rel_pulse();
        chk("q_cidx3", cpu_buf_idx, 3);
        chk("q_len3", cpu_frame_len, 13);
        chk("q_valid3", cpu_frame_valid, 1);
        rel_pulse();
        chk("empty_valid", cpu_frame_valid, 0);
        chk("empty_cidx", cpu_buf_idx, 0);
        rel_pulse();
        chk("rel0_valid", cpu_frame_valid, 0);
        chk("rel0_cidx", cpu_buf_idx, 0);
        chk("rel0_ridx", rx_buf_idx, 0);
        send_frame(11'd77, 1'b1, 2, acks, first);
        chk("after_cidx", cpu_buf_idx, 0);
        chk("after_len", cpu_frame_len, 77);
        chk("after_valid", cpu_frame_valid, 1);

        // 5: bad-CRC frame
        do_reset();
        send_frame(11'd60, 1'b0, 3, acks, first);
        chk("crc_acks", acks, 1);
`ifdef IOB_ETH_RX_CRC_DROP_EN
        chk("crc_valid", cpu_frame_valid, 0);
        chk("crc_cnt", crc_err_cnt, 1);
        chk("crc_ridx", rx_buf_idx, 0);
        send_frame(11'd61, 1'b1, 3, acks, first);
        chk("crc_next_cidx", cpu_buf_idx, 0);
        chk("crc_next_len", cpu_frame_len, 61);
        chk("crc_next_err", cpu_crc_err, 0);
`else
        chk("crc_valid", cpu_frame_valid, 1);
        chk("crc_err", cpu_crc_err, 1);
        chk("crc_len", cpu_frame_len, 60);
        chk("crc_cnt", crc_err_cnt, 0);
        chk("crc_ridx", rx_buf_idx, 1);
        send_frame(11'd61, 1'b1, 3, acks, first);
        rel_pulse();
        chk("crc_next_cidx", cpu_buf_idx, 1);
        chk("crc_next_len", cpu_frame_len, 61);
        chk("crc_next_err", cpu_crc_err, 0);
`endif

        // 6: asynchronous reset mid-FILL with two frames queued
        do_reset();
        send_frame(11'd30, 1'b1, 2, acks, first);
        send_frame(11'd31, 1'b1, 2, acks, first);
        rx_frame_done = 1'b1;
        rx_frame_len  = 11'd32;
        #1;
        rst = 1'b1;
        #1;
        chk("arst_avail", rx_buf_avail, 0);
        chk("arst_ridx", rx_buf_idx, 0);
        chk("arst_valid", cpu_frame_valid, 0);
        chk("arst_irq", irq, 0);
        chk("arst_ack", rx_ack, 0);
        chk("arst_cidx", cpu_buf_idx, 0);
        rx_frame_done = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        tick();

        // cnt_clr coinciding with a drop
        for (int i = 0; i < 4; i++) send_frame(11'(40 + i), 1'b1, 2, acks, first);
        send_frame(11'd50, 1'b1, 2, acks, first);
        chk("clr_pre", drop_cnt, 1);
        rx_frame_done = 1'b1;
        cnt_clr       = 1'b1;
        tick();
        cnt_clr = 1'b0;
        chk("clr_ack", rx_ack, 1);
        chk("clr_drop", drop_cnt, 0);
        tick();
        rx_frame_done = 1'b0;
        tick();
        tick();
        send_frame(11'd51, 1'b1, 2, acks, first);
        chk("clr_post", drop_cnt, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
